// File: rtl/pairhmm_result_drain.sv
// Drains 128-bit PairHMM result words into four MSB-first 32-bit beats, checks pair order, counts packets.
// Latency: FIFO_RD_LAT+1 cycles from rden to the first beat; a stalled host holds the word and the FIFO stays unread.
module pairhmm_result_drain #(
   parameter int FIFO_RD_LAT = 1,
   parameter int CNT_W       = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             result_fifo_empty,
   output logic             result_fifo_rden,
   input  logic [127:0]     result_fifo_rdat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_last,
   output logic             seq_err,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

   localparam logic [1:0] RD_LAT = 2'(FIFO_RD_LAT);

   state_t       state;
   logic [127:0] hold;
   logic [1:0]   beat;
   logic [1:0]   lat_cnt;
   logic [15:0]  expected_idx;
   logic [15:0]  rx_idx;

   assign rx_idx = result_fifo_rdat[111:96];

   function automatic logic [31:0] beat_word(input logic [127:0] w, input logic [1:0] b);
      logic [31:0] r;
      case (b)
         2'd0:    r = w[127:96];
         2'd1:    r = w[95:64];
         2'd2:    r = w[63:32];
         default: r = w[31:0];
      endcase
      return r;
   endfunction

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state            <= IDLE;
         result_fifo_rden <= 1'b0;
         out_valid        <= 1'b0;
         out_data         <= 32'd0;
         out_last         <= 1'b0;
         seq_err          <= 1'b0;
         pkt_cnt          <= '0;
         err_cnt          <= '0;
         expected_idx     <= 16'd0;
         hold             <= 128'd0;
         beat             <= 2'd0;
         lat_cnt          <= 2'd0;
      end else begin
         result_fifo_rden <= 1'b0;
         case (state)
            IDLE: begin
               if (!result_fifo_empty) begin
                  result_fifo_rden <= 1'b1;
                  lat_cnt          <= 2'd0;
                  state            <= WAIT;
               end
            end
            WAIT: begin
               // lat_cnt is 0 in the rden cycle, so the match lands FIFO_RD_LAT cycles later
               if (lat_cnt == RD_LAT) begin
                  hold      <= result_fifo_rdat;
                  beat      <= 2'd0;
                  out_valid <= 1'b1;
                  out_data  <= result_fifo_rdat[127:96];
                  out_last  <= 1'b0;
                  if (rx_idx != expected_idx) begin
                     seq_err <= 1'b1;
                     if (err_cnt != '1)
                        err_cnt <= err_cnt + CNT_W'(1);
                  end
                  expected_idx <= result_fifo_rdat[0] ? 16'd0 : rx_idx + 16'd1;
                  state        <= SEND;
               end else begin
                  lat_cnt <= lat_cnt + 2'd1;
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (beat == 2'd3) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (hold[0])
                        pkt_cnt <= pkt_cnt + CNT_W'(1);
                     if (!result_fifo_empty) begin
                        result_fifo_rden <= 1'b1;
                        lat_cnt          <= 2'd0;
                        state            <= WAIT;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     beat     <= beat + 2'd1;
                     out_data <= beat_word(hold, beat + 2'd1);
                     out_last <= (beat == 2'd2) && hold[0];
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pairhmm_result_drain.sv
// Bench for pairhmm_result_drain: two instances (read latency 1 / wide counters, latency 2 / 2-bit counters) share stimulus.
module tb_pairhmm_result_drain;

   logic         sys_clk = 1'b0;
   logic         sys_rst = 1'b1;
   logic         out_ready = 1'b0;
   logic         fifo_empty [2];
   logic [127:0] rdat [2];
   logic         rden [2];
   logic         out_valid [2];
   logic         out_last [2];
   logic         seq_err [2];
   logic [31:0]  out_data [2];
   logic [15:0]  pc0, ec0;
   logic [1:0]   pc1, ec1;

   int total = 0;
   int bad   = 0;

   always #5 sys_clk = ~sys_clk;

   pairhmm_result_drain #(.FIFO_RD_LAT(1), .CNT_W(16)) dut0 (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .result_fifo_empty(fifo_empty[0]), .result_fifo_rden(rden[0]), .result_fifo_rdat(rdat[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]), .out_last(out_last[0]),
      .seq_err(seq_err[0]), .pkt_cnt(pc0), .err_cnt(ec0));

   pairhmm_result_drain #(.FIFO_RD_LAT(2), .CNT_W(2)) dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .result_fifo_empty(fifo_empty[1]), .result_fifo_rden(rden[1]), .result_fifo_rdat(rdat[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]), .out_last(out_last[1]),
      .seq_err(seq_err[1]), .pkt_cnt(pc1), .err_cnt(ec1));

   // FIFO models and observation state
   logic [127:0] fq0 [$];
   logic [127:0] fq1 [$];
   logic [127:0] pend [2];
   int           dly [2];
   int           outst [2], bw [2];
   int           rden_cnt [2], rden_bad [2], stall_bad [2], valid_cyc [2];
   logic         prev_rden [2], stalled [2];
   logic [32:0]  stall_val [2];
   logic [32:0]  obs_dat [2][256];
   int           obs_cyc [2][256];
   int           obs_n [2];
   logic [32:0]  exp_dat [256];
   int           exp_n;
   int           cyc = 0;
   int           rdy_mode = 0;

   // reference model: totals since reset and the next expected pair index
   int           tot_pkt = 0, tot_err = 0;
   logic [15:0]  m_idx = 16'd0;

   function automatic logic [127:0] junk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [127:0] mk_word(input logic [15:0] pkt, input logic [15:0] idx, input logic eop);
      logic [127:0] w;
      w = junk();
      w[127:112] = pkt;
      w[111:96]  = idx;
      w[0]       = eop;
      return w;
   endfunction

   function automatic logic [15:0] exp_pkt(input int i);
      return (i == 0) ? 16'(tot_pkt % 65536) : 16'(tot_pkt % 4);
   endfunction

   function automatic logic [15:0] exp_err(input int i);
      if (i == 0) return (tot_err > 65535) ? 16'hFFFF : 16'(tot_err);
      return (tot_err > 3) ? 16'd3 : 16'(tot_err);
   endfunction

   function automatic logic [15:0] act_pkt(input int i);
      return (i == 0) ? pc0 : {14'd0, pc1};
   endfunction

   function automatic logic [15:0] act_err(input int i);
      return (i == 0) ? ec0 : {14'd0, ec1};
   endfunction

   task automatic push_word(input logic [127:0] w);
      fq0.push_back(w);
      fq1.push_back(w);
      fifo_empty[0] = 1'b0;
      fifo_empty[1] = 1'b0;
      if (w[111:96] != m_idx) tot_err++;
      m_idx = w[0] ? 16'd0 : w[111:96] + 16'd1;
      if (w[0]) tot_pkt++;
      for (int b = 0; b < 4; b++) begin
         exp_dat[exp_n] = {(b == 3) && w[0], w[127-32*b -: 32]};
         exp_n++;
      end
   endtask

   task automatic clear_obs();
      exp_n = 0;
      for (int i = 0; i < 2; i++) obs_n[i] = 0;
   endtask

   // one clock: drive ready, record accepted beats, run the FIFO models
   task automatic step();
      @(negedge sys_clk);
      cyc++;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
      for (int i = 0; i < 2; i++) begin
         if (out_valid[i]) valid_cyc[i]++;
         if (stalled[i] && (!out_valid[i] || {out_last[i], out_data[i]} !== stall_val[i])) stall_bad[i]++;
         stalled[i]   = out_valid[i] && !out_ready;
         stall_val[i] = {out_last[i], out_data[i]};
         if (out_valid[i] && out_ready) begin
            if (obs_n[i] < 256) begin
               obs_dat[i][obs_n[i]] = {out_last[i], out_data[i]};
               obs_cyc[i][obs_n[i]] = cyc;
            end
            obs_n[i]++;
            bw[i]++;
            if (bw[i] == 4) begin
               bw[i] = 0;
               outst[i]--;
            end
         end
         if (dly[i] > 0) begin
            dly[i]--;
            rdat[i] = (dly[i] == 0) ? pend[i] : junk();
         end else begin
            rdat[i] = junk();
         end
         if (rden[i]) begin
            rden_cnt[i]++;
            if (prev_rden[i]) rden_bad[i]++;
            if (outst[i] != 0) rden_bad[i]++;
            if ((i == 0 ? fq0.size() : fq1.size()) == 0) begin
               rden_bad[i]++;
            end else begin
               pend[i] = (i == 0) ? fq0.pop_front() : fq1.pop_front();
               dly[i]  = i + 1;
               outst[i]++;
            end
         end
         prev_rden[i]  = rden[i];
         fifo_empty[i] = ((i == 0) ? fq0.size() : fq1.size()) == 0;
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int c = 0; c < budget && !(obs_n[0] >= exp_n && obs_n[1] >= exp_n); c++) step();
      repeat (4) step();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge sys_clk);
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({rden[i], out_valid[i], out_last[i], seq_err[i], out_data[i]} !== 36'd0) begin
            bad++;
            $display("FAIL reset_outputs inst%0d got rden=%0b vld=%0b last=%0b err=%0b data=%h want all 0",
                     i, rden[i], out_valid[i], out_last[i], seq_err[i], out_data[i]);
         end
         total++;
         if (act_pkt(i) !== 16'd0 || act_err(i) !== 16'd0) begin
            bad++;
            $display("FAIL reset_counters inst%0d got pkt=%0d err=%0d want 0 0", i, act_pkt(i), act_err(i));
         end
      end
      sys_rst = 1'b0;
   endtask

   task automatic test_single_packet();
      clear_obs();
      rdy_mode = 0;
      for (int i = 0; i < 2; i++) begin rden_cnt[i] = 0; rden_bad[i] = 0; end
      for (int k = 0; k < 3; k++) push_word(mk_word(16'h0005, 16'(k), k == 2));
      wait_drain(200);
      for (int i = 0; i < 2; i++) begin
         int first_bad;
         first_bad = -1;
         for (int k = exp_n - 1; k >= 0; k--) if (obs_dat[i][k] !== exp_dat[k]) first_bad = k;
         total++;
         if (obs_n[i] != exp_n || first_bad >= 0) begin
            bad++;
            $display("FAIL single_beats inst%0d got n=%0d want n=%0d first_bad_beat=%0d", i, obs_n[i], exp_n, first_bad);
         end
         total++;
         if (rden_cnt[i] != 3 || rden_bad[i] != 0) begin
            bad++;
            $display("FAIL single_rden inst%0d got pulses=%0d illegal=%0d want 3 0", i, rden_cnt[i], rden_bad[i]);
         end
         total++;
         if (act_pkt(i) !== exp_pkt(i) || seq_err[i] !== 1'b0 || act_err(i) !== exp_err(i)) begin
            bad++;
            $display("FAIL single_counters inst%0d got pkt=%0d seq=%0b err=%0d want %0d 0 %0d",
                     i, act_pkt(i), seq_err[i], act_err(i), exp_pkt(i), exp_err(i));
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_obs();
      rdy_mode = 0;
      for (int k = 0; k < 4; k++) push_word(mk_word(16'h0006, 16'(k), k == 3));
      wait_drain(200);
      for (int i = 0; i < 2; i++) begin
         int first_bad, gap_bad;
         first_bad = -1;
         gap_bad   = -1;
         for (int k = exp_n - 1; k >= 0; k--) if (obs_dat[i][k] !== exp_dat[k]) first_bad = k;
         for (int k = obs_n[i] - 1; k >= 1 && k < 256; k--)
            if (obs_cyc[i][k] - obs_cyc[i][k-1] != ((k % 4 == 0) ? i + 3 : 1)) gap_bad = k;
         total++;
         if (obs_n[i] != exp_n || first_bad >= 0) begin
            bad++;
            $display("FAIL b2b_beats inst%0d got n=%0d want n=%0d first_bad_beat=%0d", i, obs_n[i], exp_n, first_bad);
         end
         total++;
         if (gap_bad >= 0) begin
            bad++;
            $display("FAIL b2b_timing inst%0d beat %0d gap got=%0d want=%0d", i, gap_bad,
                     obs_cyc[i][gap_bad] - obs_cyc[i][gap_bad-1], (gap_bad % 4 == 0) ? i + 3 : 1);
         end
      end
   endtask

   task automatic test_backpressure();
      clear_obs();
      rdy_mode = 1;
      for (int i = 0; i < 2; i++) stall_bad[i] = 0;
      for (int p = 0; p < 2; p++) begin
         int len;
         logic [15:0] pid;
         len = $urandom_range(1, 4);
         pid = 16'($urandom);
         for (int k = 0; k < len; k++) push_word(mk_word(pid, 16'(k), k == len - 1));
      end
      wait_drain(600);
      for (int i = 0; i < 2; i++) begin
         int first_bad;
         first_bad = -1;
         for (int k = exp_n - 1; k >= 0; k--) if (obs_dat[i][k] !== exp_dat[k]) first_bad = k;
         total++;
         if (obs_n[i] != exp_n || first_bad >= 0) begin
            bad++;
            $display("FAIL bp_beats inst%0d got n=%0d want n=%0d first_bad_beat=%0d", i, obs_n[i], exp_n, first_bad);
         end
         total++;
         if (stall_bad[i] != 0) begin
            bad++;
            $display("FAIL bp_stable inst%0d got unstable_stalls=%0d want 0", i, stall_bad[i]);
         end
         total++;
         if (act_pkt(i) !== exp_pkt(i)) begin
            bad++;
            $display("FAIL bp_pkt_cnt inst%0d got %0d want %0d", i, act_pkt(i), exp_pkt(i));
         end
      end
   endtask

   task automatic test_order_error();
      clear_obs();
      rdy_mode = 0;
      push_word(mk_word(16'h0007, 16'd0, 1'b0));
      push_word(mk_word(16'h0007, 16'd2, 1'b0));
      push_word(mk_word(16'h0007, 16'd3, 1'b1));
      push_word(mk_word(16'h0008, 16'd0, 1'b1));
      wait_drain(300);
      for (int i = 0; i < 2; i++) begin
         int first_bad;
         first_bad = -1;
         for (int k = exp_n - 1; k >= 0; k--) if (obs_dat[i][k] !== exp_dat[k]) first_bad = k;
         total++;
         if (obs_n[i] != exp_n || first_bad >= 0) begin
            bad++;
            $display("FAIL order_beats inst%0d got n=%0d want n=%0d first_bad_beat=%0d", i, obs_n[i], exp_n, first_bad);
         end
         total++;
         if (seq_err[i] !== 1'b1 || act_err(i) !== exp_err(i) || act_pkt(i) !== exp_pkt(i)) begin
            bad++;
            $display("FAIL order_counters inst%0d got seq=%0b err=%0d pkt=%0d want 1 %0d %0d",
                     i, seq_err[i], act_err(i), act_pkt(i), exp_err(i), exp_pkt(i));
         end
      end
   endtask

   task automatic test_saturate_random();
      clear_obs();
      rdy_mode = 1;
      for (int k = 0; k < 12; k++) begin
         logic [15:0] idx;
         idx = m_idx;
         if (k < 4 || $urandom_range(0, 1) == 1) idx = m_idx + 16'($urandom_range(1, 6));
         push_word(mk_word(16'($urandom), idx, $urandom_range(0, 2) == 0));
      end
      wait_drain(1500);
      for (int i = 0; i < 2; i++) begin
         int first_bad;
         first_bad = -1;
         for (int k = exp_n - 1; k >= 0; k--) if (obs_dat[i][k] !== exp_dat[k]) first_bad = k;
         total++;
         if (obs_n[i] != exp_n || first_bad >= 0) begin
            bad++;
            $display("FAIL rand_beats inst%0d got n=%0d want n=%0d first_bad_beat=%0d", i, obs_n[i], exp_n, first_bad);
         end
         total++;
         if (act_err(i) !== exp_err(i) || act_pkt(i) !== exp_pkt(i)) begin
            bad++;
            $display("FAIL rand_counters inst%0d got err=%0d pkt=%0d want %0d %0d",
                     i, act_err(i), act_pkt(i), exp_err(i), exp_pkt(i));
         end
      end
   endtask

   task automatic test_empty_idle();
      int rc [2], vc [2];
      rdy_mode = 0;
      for (int i = 0; i < 2; i++) begin rc[i] = rden_cnt[i]; vc[i] = valid_cyc[i]; end
      repeat (50) step();
      for (int i = 0; i < 2; i++) begin
         total++;
         if (rden_cnt[i] != rc[i] || valid_cyc[i] != vc[i]) begin
            bad++;
            $display("FAIL empty_idle inst%0d got rden_pulses=%0d valid_cycles=%0d want 0 0",
                     i, rden_cnt[i] - rc[i], valid_cyc[i] - vc[i]);
         end
      end
   endtask

   task automatic test_reset_mid_word();
      clear_obs();
      rdy_mode = 0;
      push_word(mk_word(16'h0009, m_idx, 1'b0));
      for (int c = 0; c < 100 && !(obs_n[0] >= 2 && obs_n[1] >= 2); c++) step();
      rdy_mode = 2;
      sys_rst  = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (out_valid[i] !== 1'b0 || seq_err[i] !== 1'b0 || act_pkt(i) !== 16'd0 || act_err(i) !== 16'd0) begin
            bad++;
            $display("FAIL midreset_async inst%0d got vld=%0b seq=%0b pkt=%0d err=%0d want all 0",
                     i, out_valid[i], seq_err[i], act_pkt(i), act_err(i));
         end
         outst[i] = 0; bw[i] = 0; dly[i] = 0; stalled[i] = 1'b0; prev_rden[i] = 1'b0;
      end
      fq0.delete();
      fq1.delete();
      tot_pkt = 0;
      tot_err = 0;
      m_idx   = 16'd0;
      repeat (2) step();
      sys_rst = 1'b0;
      clear_obs();
      rdy_mode = 0;
      push_word(mk_word(16'h000A, 16'd0, 1'b1));
      wait_drain(100);
      for (int i = 0; i < 2; i++) begin
         int first_bad;
         first_bad = -1;
         for (int k = exp_n - 1; k >= 0; k--) if (obs_dat[i][k] !== exp_dat[k]) first_bad = k;
         total++;
         if (obs_n[i] != exp_n || first_bad >= 0) begin
            bad++;
            $display("FAIL midreset_beats inst%0d got n=%0d want n=%0d first_bad_beat=%0d", i, obs_n[i], exp_n, first_bad);
         end
         total++;
         if (seq_err[i] !== 1'b0 || act_pkt(i) !== 16'd1 || act_err(i) !== 16'd0) begin
            bad++;
            $display("FAIL midreset_counters inst%0d got seq=%0b pkt=%0d err=%0d want 0 1 0",
                     i, seq_err[i], act_pkt(i), act_err(i));
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         fifo_empty[i] = 1'b1; rdat[i] = 128'd0; pend[i] = 128'd0; dly[i] = 0;
         outst[i] = 0; bw[i] = 0; rden_cnt[i] = 0; rden_bad[i] = 0; stall_bad[i] = 0;
         valid_cyc[i] = 0; prev_rden[i] = 1'b0; stalled[i] = 1'b0; stall_val[i] = 33'd0; obs_n[i] = 0;
      end
      exp_n = 0;
      test_reset();
      test_single_packet();
      test_back_to_back();
      test_backpressure();
      test_order_error();
      test_saturate_random();
      test_empty_idle();
      test_reset_mid_word();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
